// File: rtl/inst_fetch_if.sv
// Bundles the instruction-fetch stage's control, memory and IF/ID signals.
// The master modport is the fetch stage; the slave modport is its environment.
interface inst_fetch_if;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] inst_o;
  logic [31:0] pc4_o;
  logic        valid_o;
  logic        halt_o;
  logic [31:0] fetch_cnt;

  modport master (
    input  stall, branch_taken, branch_target, jump, jump_target, imem_data,
    output imem_addr, inst_o, pc4_o, valid_o, halt_o, fetch_cnt
  );

  modport slave (
    output stall, branch_taken, branch_target, jump, jump_target, imem_data,
    input  imem_addr, inst_o, pc4_o, valid_o, halt_o, fetch_cnt
  );
endinterface

// File: rtl/inst_fetch.sv
// IF stage: owns the PC, fetches from combinational imem, fills IF/ID, halts on bad PC.
// Optional macro BRANCH_DELAY_SLOT_EN: a redirect latches the word at the old PC as a delay slot.
module inst_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 128
) (
  input  logic          clk,
  input  logic          rst,
  inst_fetch_if.master  bus
);

  localparam logic [31:0] PC_LIMIT = 32'(IMEM_WORDS * 4);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] cnt_q, cnt_d;

  logic        redirect;
  logic [31:0] target;
  logic        fault;
  logic [31:0] pc_plus4;

  // Branch is older than the jump in ID, so it wins when both fire.
  assign redirect = bus.branch_taken | bus.jump;
  assign target   = bus.branch_taken ? bus.branch_target : bus.jump_target;
  assign fault    = (pc_q[1:0] != 2'b00) || (pc_q >= PC_LIMIT);
  assign pc_plus4 = pc_q + 32'd4;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= 32'd0;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: state_d = RUN;
      RUN: begin
        if (redirect) begin
          // A redirect still loads the PC in a fault cycle; the target is checked next cycle.
          pc_d = target;
`ifdef BRANCH_DELAY_SLOT_EN
          if (fault) begin
            inst_d  = 32'd0;
            valid_d = 1'b0;
          end else if (!bus.stall) begin
            inst_d  = bus.imem_data;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            cnt_d   = cnt_q + 32'd1;
          end
`else
          inst_d  = 32'd0;
          valid_d = 1'b0;
`endif
        end else if (fault) begin
          state_d = HALT;
          inst_d  = 32'd0;
          valid_d = 1'b0;
        end else if (!bus.stall) begin
          inst_d  = bus.imem_data;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
          cnt_d   = cnt_q + 32'd1;
          pc_d    = pc_plus4;
        end
      end
      HALT: ;
      default: state_d = IDLE;
    endcase
  end

  assign bus.imem_addr = pc_q;
  assign bus.inst_o    = inst_q;
  assign bus.pc4_o     = pc4_q;
  assign bus.valid_o   = valid_q;
  assign bus.halt_o    = (state_q == HALT);
  assign bus.fetch_cnt = cnt_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: driver runs a reference model and queues expected
// IF/ID state; a monitor pops and compares one entry per clock.
module tb_inst_fetch;

  localparam int WORDS = 128;

  logic clk;
  logic rst;
  inst_fetch_if bus();

  inst_fetch #(.RESET_PC(32'h0), .IMEM_WORDS(WORDS)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [WORDS];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a[18:9] == 10'd0) return mem[a[8:2]];
    return 32'hDEAD_BEEF;
  endfunction

  always_comb bus.imem_data = mem_rd(bus.imem_addr);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] pc4;
    logic [31:0] cnt;
    logic        valid;
    logic        halt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   txn    = 0;

  function void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Reference model: 0 = settle after reset, 1 = fetching, 2 = halted.
  int          m_mode;
  logic [31:0] m_pc, m_inst, m_pc4, m_cnt;
  logic        m_valid;

  function void model_step(input logic r, input logic s, input logic b, input logic [31:0] bt,
                           input logic j, input logic [31:0] jt);
    bit bad;
    if (!r) begin
      m_mode = 0; m_pc = 32'h0; m_inst = 0; m_pc4 = 0; m_valid = 0; m_cnt = 0;
      return;
    end
    if (m_mode == 0) begin
      m_mode = 1;
      return;
    end
    if (m_mode == 2) return;
    bad = (m_pc % 4 != 0) || (m_pc >= WORDS * 4);
    if (b || j) begin
`ifdef BRANCH_DELAY_SLOT_EN
      if (bad) begin
        m_inst = 0; m_valid = 0;
      end else if (!s) begin
        m_inst = mem_rd(m_pc); m_pc4 = m_pc + 4; m_valid = 1; m_cnt = m_cnt + 1;
      end
`else
      m_inst = 0; m_valid = 0;
`endif
      m_pc = b ? bt : jt;
    end else if (bad) begin
      m_mode = 2; m_inst = 0; m_valid = 0;
    end else if (!s) begin
      m_inst = mem_rd(m_pc); m_pc4 = m_pc + 4; m_valid = 1; m_cnt = m_cnt + 1;
      m_pc = m_pc + 4;
    end
  endfunction

  task automatic drive(input logic r, input logic s, input logic b, input logic [31:0] bt,
                       input logic j, input logic [31:0] jt);
    exp_t e;
    @(negedge clk);
    rst = r; bus.stall = s; bus.branch_taken = b; bus.branch_target = bt;
    bus.jump = j; bus.jump_target = jt;
    model_step(r, s, b, bt, j, jt);
    e.pc = m_pc; e.inst = m_inst; e.pc4 = m_pc4; e.cnt = m_cnt;
    e.valid = m_valid; e.halt = (m_mode == 2);
    exp_q.push_back(e);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      txn++;
      chk("pc",        bus.imem_addr, mon_e.pc);
      chk("inst_o",    bus.inst_o,    mon_e.inst);
      chk("pc4_o",     bus.pc4_o,     mon_e.pc4);
      chk("fetch_cnt", bus.fetch_cnt, mon_e.cnt);
      chk("valid_o",   32'(bus.valid_o), 32'(mon_e.valid));
      chk("halt_o",    32'(bus.halt_o),  32'(mon_e.halt));
      $display("txn %0d: pc=%h inst=%h pc4=%h valid=%b halt=%b cnt=%0d",
               txn, bus.imem_addr, bus.inst_o, bus.pc4_o, bus.valid_o, bus.halt_o, bus.fetch_cnt);
    end
  end

  initial begin
    logic r, s, b, j;
    logic [31:0] bt, jt;
    rst = 1'b0; bus.stall = 0; bus.branch_taken = 0; bus.branch_target = 0;
    bus.jump = 0; bus.jump_target = 0;
    for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
    mem[0] = 32'h0000_4020; mem[1] = 32'h0000_4820; mem[2] = 32'h0000_5020;

    // Reset, settle cycle, three fetches.
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    run(4);
    @(posedge clk); #2;
    chk("t1_cnt",  bus.fetch_cnt, 32'd3);
    chk("t1_inst", bus.inst_o,    32'h0000_5020);
    chk("t1_pc4",  bus.pc4_o,     32'h0000_000C);

    // Stall for two cycles at pc=0x10, then release.
    run(1);
    drive(1, 1, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0);
    run(1);
    @(posedge clk); #2;
    chk("t2_pc4", bus.pc4_o, 32'h0000_0014);

    // Branch, jump and stall together: branch target wins.
    drive(1, 1, 1, 32'h30, 1, 32'h40);
    @(posedge clk); #2;
    chk("t3_pc", bus.imem_addr, 32'h0000_0030);

    // Jump to 0x2C, then fetch mem[11].
    drive(1, 0, 0, 0, 1, 32'h2C);
    run(1);
    @(posedge clk); #2;
    chk("t4_inst", bus.inst_o, mem[11]);
    chk("t4_pc4",  bus.pc4_o,  32'h0000_0030);

    // Free-run past the last legal word into the fault.
    for (int i = 0; i < 200 && m_pc != 32'h200; i++) run(1);
    run(1);
    drive(1, 0, 0, 0, 1, 32'h10);
    drive(1, 0, 1, 32'h20, 0, 0);
    @(posedge clk); #2;
    chk("t5_halt", 32'(bus.halt_o), 32'd1);
    chk("t5_pc",   bus.imem_addr,   32'h0000_0200);

    // Reset out of HALT, misaligned jump, HALT, reset and resume.
    drive(0, 0, 0, 0, 0, 0);
    run(3);
    drive(1, 0, 0, 0, 1, 32'h06);
    run(2);
    drive(0, 0, 0, 0, 0, 0);
    run(4);
    @(posedge clk); #2;
    chk("t6_cnt", bus.fetch_cnt, 32'd3);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      r  = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
      s  = ($urandom_range(0, 99) < 20);
      b  = ($urandom_range(0, 99) < 8);
      j  = ($urandom_range(0, 99) < 8);
      bt = ($urandom_range(0, 9) == 0) ? 32'($urandom) : 32'($urandom_range(0, 135)) << 2;
      jt = ($urandom_range(0, 9) == 0) ? 32'($urandom) : 32'($urandom_range(0, 135)) << 2;
      drive(r, s, b, bt, j, jt);
    end

    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
